// File: rtl/cmd_write.sv
// -----------------------------------------------------------------------------
// cmd_write - SD command token serialiser (transmit side of the CMD line)
//
// Sends one 48-bit command token MSB first:
//   start bit (0), transmission bit (1), 6-bit index, 32-bit argument,
//   CRC7 (x^7 + x^3 + 1, initial value 0) and end bit (1).
// The CRC7 is accumulated bit by bit while the index and argument go out.
// Protocol timing advances only on clk_i edges where clk_en_i (the SD clock
// tick) is high. Synchronous reset is the only exception: it takes effect on
// any clk_i edge.
//
// Optional feature (macro SDHCI_CMD_NCC_EN):
//   When defined, the end bit is followed by NCC_CYCLES enabled cycles. During
//   these cycles the line is released and busy_o stays high.
//   When undefined, END returns straight to IDLE. NCC_CYCLES then only sizes
//   the bit counter.
//
// Parameters:
//   NCC_CYCLES   idle SD-clock cycles after the end bit (feature builds only)
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous reset, active high
//   clk_en_i     SD clock tick qualifier
//   start_i      send request, sampled only in IDLE on enabled edges
//   cmd_index_i  command index, captured on acceptance
//   cmd_arg_i    command argument, captured on acceptance
//   cmd_o        serial CMD data towards the pad
//   cmd_oe_o     CMD pad output enable
//   busy_o       high from acceptance until the block is back in IDLE
//   done_o       single clk_i-cycle pulse when the end bit has completed
//   crc7_o       CRC7 of the last frame, snapshotted when the CRC field starts
// -----------------------------------------------------------------------------
module cmd_write #(
  parameter int unsigned NCC_CYCLES = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clk_en_i,
  input  logic        start_i,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  output logic        cmd_o,
  output logic        cmd_oe_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [6:0]  crc7_o
);

  // The bit counter must cover the 40 payload bits. When NCC_CYCLES is
  // larger, it must also cover the NCC window.
  localparam int CNT_W = (NCC_CYCLES > 32'd40) ? $clog2(NCC_CYCLES) : 6;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(6'd39);
  localparam logic [CNT_W-1:0] LAST_CRC = CNT_W'(6'd6);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
`ifdef SDHCI_CMD_NCC_EN
  localparam logic [CNT_W-1:0] NCC_LAST = CNT_W'(NCC_CYCLES - 32'd1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_CRC   = 3'd2,
`ifdef SDHCI_CMD_NCC_EN
    ST_END   = 3'd3,
    ST_NCC   = 3'd4
`else
    ST_END   = 3'd3
`endif
  } state_e;

  // One serial CRC7 step: feedback taps at x^3 and x^0.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc,
                                           input logic       bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  endfunction

  state_e           state_q, state_d;
  logic [39:0]      shift_q, shift_d;
  logic [6:0]       crc_q,   crc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             cmd_q,   cmd_d;
  logic             oe_q,    oe_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [6:0]       crc7_q,  crc7_d;
  logic [6:0]       crc_next_s;

  // Next-state and next-output logic. Nothing moves unless clk_en_i is high.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    crc7_d     = crc7_q;
    // The bit currently on the line is the shift register MSB.
    crc_next_s = crc7_step(crc_q, shift_q[39]);

    if (clk_en_i) begin
      case (state_q)
        ST_IDLE: begin
          cmd_d  = 1'b1;
          oe_d   = 1'b0;
          busy_d = 1'b0;
          if (start_i) begin
            shift_d = {1'b0, 1'b1, cmd_index_i, cmd_arg_i};
            crc_d   = 7'd0;
            cnt_d   = '0;
            // The start bit is driven in the cycle right after acceptance.
            cmd_d   = 1'b0;
            oe_d    = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_SHIFT: begin
          crc_d   = crc_next_s;
          shift_d = {shift_q[38:0], 1'b0};
          if (cnt_q == LAST_BIT) begin
            // Last payload bit: the finished CRC drives the line next and
            // is published on crc7_o.
            cnt_d   = '0;
            cmd_d   = crc_next_s[6];
            crc7_d  = crc_next_s;
            state_d = ST_CRC;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            cmd_d   = shift_q[38];
          end
        end

        ST_CRC: begin
          crc_d = {crc_q[5:0], 1'b0};
          if (cnt_q == LAST_CRC) begin
            cnt_d   = '0;
            cmd_d   = 1'b1;
            state_d = ST_END;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            cmd_d   = crc_q[5];
          end
        end

        ST_END: begin
          done_d = 1'b1;
          cmd_d  = 1'b1;
          oe_d   = 1'b0;
          cnt_d  = '0;
`ifdef SDHCI_CMD_NCC_EN
          busy_d  = 1'b1;
          state_d = ST_NCC;
`else
          busy_d  = 1'b0;
          state_d = ST_IDLE;
`endif
        end

`ifdef SDHCI_CMD_NCC_EN
        ST_NCC: begin
          cmd_d = 1'b1;
          oe_d  = 1'b0;
          if (cnt_q == NCC_LAST) begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            busy_d  = 1'b1;
          end
        end
`endif

        default: begin
          cnt_d   = '0;
          cmd_d   = 1'b1;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      // No SD clock tick: hold everything. done_o is already cleared above.
      state_d = state_q;
    end
  end

  // State and registered outputs. Reset wins over clk_en_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      shift_q <= 40'd0;
      crc_q   <= 7'd0;
      cnt_q   <= '0;
      cmd_q   <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      crc7_q  <= 7'd0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      crc7_q  <= crc7_d;
    end
  end

  assign cmd_o    = cmd_q;
  assign cmd_oe_o = oe_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign crc7_o   = crc7_q;

endmodule

// File: tb/tb_cmd_write.sv
// Directed bench for cmd_write: a table of command frames with known tokens,
// plus hand-written sequences for mid-frame reset, a start request without
// a clock tick, and (in feature builds) the NCC window.
module tb_cmd_write;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clk_en_i;
  logic        start_i;
  logic [5:0]  cmd_index_i;
  logic [31:0] cmd_arg_i;
  logic        cmd_o;
  logic        cmd_oe_o;
  logic        busy_o;
  logic        done_o;
  logic [6:0]  crc7_o;

  int total = 0;
  int bad   = 0;

`ifdef SDHCI_CMD_NCC_EN
  localparam logic NCC_ON = 1'b1;
`else
  localparam logic NCC_ON = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  cmd_write #(.NCC_CYCLES(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clk_en_i    (clk_en_i),
    .start_i     (start_i),
    .cmd_index_i (cmd_index_i),
    .cmd_arg_i   (cmd_arg_i),
    .cmd_o       (cmd_o),
    .cmd_oe_o    (cmd_oe_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .crc7_o      (crc7_o)
  );

  typedef struct {
    string       name;
    logic [5:0]  idx;
    logic [31:0] arg;
    int          period;    // clk_en_i high once every 'period' cycles
    logic        hold;      // keep start_i high through the frame
    logic [47:0] stream;    // expected token, MSB first
    logic [6:0]  crc;       // expected crc7_o after the frame
    logic [6:0]  prev_crc;  // crc7_o expected before the snapshot
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic en);
    clk_en_i = en;
    @(posedge clk_i);
    #1;
  endtask

  // Let any NCC window finish before a new request is issued.
  task automatic drain();
    int n;
    n = 0;
    while (busy_o && n < 64) begin
      tick(1'b1);
      n++;
    end
  endtask

  task automatic do_frame(input vec_t v);
    logic [47:0] stream;
    int   oe_cyc, dones, unstable, crc_bad, nbits, phase, ntail;
    logic prev_cmd, en_now, accepted, finished, busy_at_done, done_at_end;
    stream = 48'd0; oe_cyc = 0; dones = 0; unstable = 0; crc_bad = 0; nbits = 0;
    accepted = 1'b0; finished = 1'b0; busy_at_done = 1'b0; done_at_end = 1'b0;
    drain();
    cmd_index_i = v.idx;
    cmd_arg_i   = v.arg;
    start_i     = 1'b1;
    phase       = 0;
    prev_cmd    = cmd_o;
    for (int c = 0; c < 400 && !finished; c++) begin
      en_now = (phase == v.period - 1);
      phase  = en_now ? 0 : phase + 1;
      tick(en_now);
      if (cmd_oe_o) oe_cyc++;
      if (done_o) dones++;
      if (!en_now && cmd_o !== prev_cmd) unstable++;
      prev_cmd = cmd_o;
      if (en_now && cmd_oe_o) begin
        if (nbits < 40 && crc7_o !== v.prev_crc) crc_bad++;
        stream = {stream[46:0], cmd_o};
        nbits++;
      end
      if (busy_o && !accepted) begin
        accepted = 1'b1;
        // Changing the inputs after acceptance must not matter.
        cmd_index_i = ~v.idx;
        cmd_arg_i   = ~v.arg;
        if (!v.hold) start_i = 1'b0;
      end
      if (accepted && !cmd_oe_o) begin
        finished     = 1'b1;
        busy_at_done = busy_o;
        done_at_end  = done_o;
      end
    end
    ntail = (v.period > 1) ? v.period - 1 : 1;
    for (int t = 0; t < ntail; t++) begin
      tick(1'b0);
      if (cmd_oe_o) oe_cyc++;
      if (done_o) dones++;
      if (cmd_o !== prev_cmd) unstable++;
      prev_cmd = cmd_o;
    end
    check({v.name, "/finished"},    64'(finished),     64'd1);
    check({v.name, "/stream"},      64'(stream),       64'(v.stream));
    check({v.name, "/crc7"},        64'(crc7_o),       64'(v.crc));
    check({v.name, "/oe_cycles"},   64'(oe_cyc),       64'(48 * v.period));
    check({v.name, "/done_count"},  64'(dones),        64'd1);
    check({v.name, "/done_at_end"}, 64'(done_at_end),  64'd1);
    check({v.name, "/cmd_stable"},  64'(unstable),     64'd0);
    check({v.name, "/crc7_held"},   64'(crc_bad),      64'd0);
    check({v.name, "/busy_at_done"}, 64'(busy_at_done), 64'(NCC_ON));
  endtask

  initial begin
    int   viol;
    int   n;
    vec_t v17;

    vecs[0] = '{"cmd0",  6'd0,  32'h0000_0000, 1, 1'b0, 48'h40_0000_0000_95, 7'h4A, 7'h00};
    vecs[1] = '{"cmd8",  6'd8,  32'h0000_01AA, 4, 1'b0, 48'h48_0000_01AA_87, 7'h43, 7'h4A};
    vecs[2] = '{"cmd55", 6'd55, 32'h0000_0000, 2, 1'b0, 48'h77_0000_0000_65, 7'h32, 7'h43};
    vecs[3] = '{"cmd17a", 6'd17, 32'h0000_0000, 1, 1'b1, 48'h51_0000_0000_55, 7'h2A, 7'h32};
    vecs[4] = '{"cmd17b", 6'd17, 32'h0000_0000, 1, 1'b0, 48'h51_0000_0000_55, 7'h2A, 7'h2A};

    rst_i = 1'b1; clk_en_i = 1'b0; start_i = 1'b0;
    cmd_index_i = 6'd0; cmd_arg_i = 32'd0;
    for (int i = 0; i < 3; i++) tick(1'b0);
    rst_i = 1'b0;
    tick(1'b0);
    check("reset/cmd",  64'(cmd_o),    64'd1);
    check("reset/oe",   64'(cmd_oe_o), 64'd0);
    check("reset/busy", 64'(busy_o),   64'd0);
    check("reset/done", 64'(done_o),   64'd0);
    check("reset/crc7", 64'(crc7_o),   64'd0);

    for (int i = 0; i < 5; i++) do_frame(vecs[i]);

    // Reset while bit 20 of a CMD0 frame is on the line, on a non-tick edge.
    drain();
    cmd_index_i = 6'd0; cmd_arg_i = 32'd0; start_i = 1'b1;
    tick(1'b1);
    start_i = 1'b0;
    check("rst_mid/accept", 64'(busy_o), 64'd1);
    for (int i = 0; i < 20; i++) tick(1'b1);
    rst_i = 1'b1;
    tick(1'b0);
    rst_i = 1'b0;
    check("rst_mid/oe",   64'(cmd_oe_o), 64'd0);
    check("rst_mid/cmd",  64'(cmd_o),    64'd1);
    check("rst_mid/busy", 64'(busy_o),   64'd0);
    check("rst_mid/done", 64'(done_o),   64'd0);
    check("rst_mid/crc7", 64'(crc7_o),   64'd0);
    viol = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      if (done_o || cmd_oe_o || busy_o) viol++;
    end
    check("rst_mid/quiet", 64'(viol), 64'd0);
    v17 = '{"cmd17_after_rst", 6'd17, 32'h0000_0000, 1, 1'b0, 48'h51_0000_0000_55, 7'h2A, 7'h00};
    do_frame(v17);

    // A start pulse with no SD clock tick must not be accepted.
    drain();
    start_i = 1'b1;
    tick(1'b0);
    start_i = 1'b0;
    viol = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1);
      if (busy_o || cmd_oe_o) viol++;
    end
    check("start_no_tick", 64'(viol), 64'd0);

`ifdef SDHCI_CMD_NCC_EN
    // NCC window after a CMD0: start_i held high must be ignored.
    do_frame(vecs[0]);
    start_i = 1'b1;
    n = 0; viol = 0;
    while (busy_o && n < 20) begin
      tick(1'b1);
      n++;
      if (cmd_oe_o || !cmd_o) viol++;
    end
    start_i = 1'b0;
    check("ncc/length",   64'(n),    64'd8);
    check("ncc/released", 64'(viol), 64'd0);
    tick(1'b1);
    check("ncc/no_queue", 64'(busy_o), 64'd0);
`else
    n = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
